// File: rtl/bist_scheduler_if.sv
// Requester and BIST-engine signal bundle for bist_scheduler.
// The slave modport is the scheduler; the master modport is the surrounding logic.
interface bist_scheduler_if #(
  parameter int NREQ  = 4,
  parameter int SIG_W = 16,
  parameter int GW    = (NREQ > 2) ? $clog2(NREQ) : 1
);
  logic [NREQ-1:0]       req;
  logic [NREQ*SIG_W-1:0] golden;
  logic [NREQ-1:0]       ack;
  logic                  pass;
  logic                  timeout_err;
  logic                  busy;
  logic [GW-1:0]         grant_id;
  logic                  bist_start;
  logic                  bist_end;
  logic [SIG_W-1:0]      signature;
  logic [15:0]           sessions;

  modport slave (
    input  req, golden, bist_end, signature,
    output ack, pass, timeout_err, busy, grant_id, bist_start, sessions
  );

  modport master (
    output req, golden, bist_end, signature,
    input  ack, pass, timeout_err, busy, grant_id, bist_start, sessions
  );
endinterface

// File: rtl/bist_scheduler.sv
// Round-robin scheduler sharing one BIST engine between NREQ requesters,
// with a start-to-done watchdog and per-requester golden signature check.
//
// state    | meaning
// IDLE     | no session, waiting for any req
// ARB      | pick next requester after ptr (round robin)
// LAUNCH   | bist_start pulse, clear watchdog timer
// WAIT_CLR | wait for the previous run's done flag to drop
// WAIT_END | wait for bist_end of this run
// CHECK    | compare signature with granted golden value
// ACK      | ack/pass/timeout_err pulse to granted requester
module bist_scheduler #(
  parameter int NREQ    = 4,
  parameter int SIG_W   = 16,
  parameter int TIMEOUT = 1023
) (
  input logic            clk,
  input logic            reset,
  bist_scheduler_if.slave bus
);
  localparam int GW = (NREQ > 2) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE, ARB, LAUNCH, WAIT_CLR, WAIT_END, CHECK, ACK
  } state_t;

  state_t          state;
  logic [GW-1:0]   ptr;
  logic [TW-1:0]   timer;
  logic            arb_hit;
  logic [GW-1:0]   arb_id;
  logic [SIG_W-1:0] gold_sel;

  // First requesting index strictly after ptr, wrapping around.
  always_comb begin
    arb_hit = 1'b0;
    arb_id  = ptr;
    for (int k = 1; k <= NREQ; k++) begin
      if (!arb_hit && bus.req[(int'(ptr) + k) % NREQ]) begin
        arb_hit = 1'b1;
        arb_id  = GW'((int'(ptr) + k) % NREQ);
      end
    end
  end

  assign gold_sel = bus.golden[int'(grant_id_q()) * SIG_W +: SIG_W];

  function automatic logic [GW-1:0] grant_id_q();
    return bus.grant_id;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      ptr             <= GW'(NREQ - 1);
      timer           <= '0;
      bus.ack         <= '0;
      bus.pass        <= 1'b0;
      bus.timeout_err <= 1'b0;
      bus.busy        <= 1'b0;
      bus.bist_start  <= 1'b0;
      bus.grant_id    <= '0;
      bus.sessions    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req) begin
            state    <= ARB;
            bus.busy <= 1'b1;
          end
        end
        ARB: begin
          if (arb_hit) begin
            bus.grant_id   <= arb_id;
            bus.bist_start <= 1'b1;
            state          <= LAUNCH;
          end else begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        end
        LAUNCH: begin
          bus.bist_start <= 1'b0;
          timer          <= '0;
          state          <= WAIT_CLR;
        end
        WAIT_CLR, WAIT_END: begin
          // Watchdog wins over bist_end; timer parks at TMAX.
          if (timer == TMAX) begin
            bus.ack               <= '0;
            bus.ack[bus.grant_id] <= 1'b1;
            bus.pass              <= 1'b0;
            bus.timeout_err       <= 1'b1;
            state                 <= ACK;
          end else begin
            timer <= timer + 1'b1;
            if (state == WAIT_CLR && !bus.bist_end)
              state <= WAIT_END;
            else if (state == WAIT_END && bus.bist_end)
              state <= CHECK;
          end
        end
        CHECK: begin
          bus.ack               <= '0;
          bus.ack[bus.grant_id] <= 1'b1;
          bus.pass              <= (bus.signature == gold_sel);
          bus.timeout_err       <= 1'b0;
          state                 <= ACK;
        end
        ACK: begin
          bus.ack         <= '0;
          bus.pass        <= 1'b0;
          bus.timeout_err <= 1'b0;
          bus.busy        <= 1'b0;
          ptr             <= bus.grant_id;
          if (bus.sessions != 16'hFFFF)
            bus.sessions <= bus.sessions + 16'd1;
          state <= IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bist_scheduler.sv
// Bench for bist_scheduler: table of single sessions, round robin, stale done,
// reset abort on the main instance, and watchdog on a TIMEOUT=20 instance.
module tb_bist_scheduler;
  localparam int NREQ  = 4;
  localparam int SIG_W = 16;
  localparam int GW    = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bist_scheduler_if #(.NREQ(NREQ), .SIG_W(SIG_W)) bus ();
  bist_scheduler_if #(.NREQ(NREQ), .SIG_W(SIG_W)) bus2 ();

  bist_scheduler #(.NREQ(NREQ), .SIG_W(SIG_W)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  bist_scheduler #(.NREQ(NREQ), .SIG_W(SIG_W), .TIMEOUT(20)) dut_to (
    .clk(clk), .reset(reset), .bus(bus2)
  );

  // Engine model: done flag drops one cycle after start, rises after eng_run more.
  logic [15:0] eng_sig;
  int          eng_run;
  int          eng_cnt;
  logic        eng_act;
  always @(posedge clk) begin
    if (reset) begin
      bus.bist_end  <= 1'b0;
      bus.signature <= '0;
      eng_act       <= 1'b0;
      eng_cnt       <= 0;
    end else if (bus.bist_start) begin
      eng_act <= 1'b1;
      eng_cnt <= eng_run;
    end else if (eng_act) begin
      if (eng_cnt == 0) begin
        bus.bist_end  <= 1'b1;
        bus.signature <= eng_sig;
        eng_act       <= 1'b0;
      end else begin
        bus.bist_end <= 1'b0;
        eng_cnt      <= eng_cnt - 1;
      end
    end
  end

  typedef struct {
    logic [GW-1:0] id;
    logic          pass;
    logic          to;
  } exp_t;

  typedef struct {
    logic [NREQ-1:0] req;
    logic [15:0]     gold;
    logic [15:0]     sig;
    int              run;
    logic [GW-1:0]   id;
    logic            pass;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_sessions = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [GW-1:0] id, input logic pass, input logic to);
    exp_t e;
    e.id = id; e.pass = pass; e.to = to;
    sb.push_back(e);
  endtask

  // Waits for one session on the main instance and checks it against the scoreboard.
  task automatic serve(input int exp_lat, input logic drop_all);
    exp_t e;
    int   lat;
    int   starts;
    lat = 0;
    while (!bus.bist_start && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("start_seen", bus.bist_start, 1);
    chk("idle_pass_low", {bus.pass, bus.timeout_err}, 0);
    starts = 1;
    lat = 0;
    while (bus.ack == '0 && lat < 2000) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      if (bus.bist_start) starts++;
    end
    if (sb.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard_empty: got ack %0h expected none", bus.ack);
      return;
    end
    e = sb.pop_front();
    chk("ack", bus.ack, 32'(1) << e.id);
    chk("grant_id", bus.grant_id, e.id);
    chk("pass", bus.pass, e.pass);
    chk("timeout_err", bus.timeout_err, e.to);
    chk("one_start", starts, 1);
    if (exp_lat >= 0) chk("latency", lat, exp_lat);
    if (drop_all) bus.req = '0;
    else bus.req[e.id] = 1'b0;
    exp_sessions++;
    @(posedge clk);
    @(negedge clk);
    chk("ack_pulse", bus.ack, 0);
    chk("busy_idle", bus.busy, 0);
    chk("sessions", bus.sessions, exp_sessions);
  endtask

  initial begin
    vec_t vt[6];
    logic [GW-1:0] rr_ids[6];
    int lat;

    // Session latency from the bist_start cycle is run+4 whether or not the
    // previous done flag is still high; an early CHECK on a stale flag would shorten it.
    vt[0] = '{req: 4'b0001, gold: 16'hA5C3, sig: 16'hA5C3, run: 650, id: 2'd0, pass: 1'b1};
    vt[1] = '{req: 4'b0100, gold: 16'h1234, sig: 16'h1235, run: 12,  id: 2'd2, pass: 1'b0};
    vt[2] = '{req: 4'b1010, gold: 16'hBEEF, sig: 16'hBEEF, run: 8,   id: 2'd3, pass: 1'b1};
    vt[3] = '{req: 4'b1010, gold: 16'h0F0F, sig: 16'h0F0E, run: 8,   id: 2'd1, pass: 1'b0};
    vt[4] = '{req: 4'b0011, gold: 16'hFFFF, sig: 16'hFFFF, run: 5,   id: 2'd0, pass: 1'b1};
    vt[5] = '{req: 4'b1000, gold: 16'h0000, sig: 16'h0000, run: 3,   id: 2'd3, pass: 1'b1};
    rr_ids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    bus.req = '0;   bus.golden = '0;
    bus2.req = '0;  bus2.golden = '0;
    bus2.bist_end = 1'b0; bus2.signature = '0;
    eng_sig = '0;   eng_run = 4;

    repeat (3) @(negedge clk);
    chk("rst_ack", bus.ack, 0);
    chk("rst_flags", {bus.pass, bus.timeout_err, bus.busy, bus.bist_start}, 0);
    chk("rst_grant", bus.grant_id, 0);
    chk("rst_sessions", bus.sessions, 0);
    chk("rst2_flags", {bus2.ack, bus2.pass, bus2.timeout_err, bus2.busy, bus2.bist_start}, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < NREQ; i++)
        bus.golden[i*SIG_W +: SIG_W] = (i == int'(vt[v].id)) ? vt[v].gold : ~vt[v].gold;
      eng_sig = vt[v].sig;
      eng_run = vt[v].run;
      push_exp(vt[v].id, vt[v].pass, 1'b0);
      bus.req = vt[v].req;
      serve(vt[v].run + 4, 1'b1);
    end

    // Round robin with all four held, each re-raising one cycle after its ack.
    for (int i = 0; i < NREQ; i++) bus.golden[i*SIG_W +: SIG_W] = 16'h5A5A;
    eng_sig = 16'h5A5A;
    eng_run = 6;
    for (int i = 0; i < 6; i++) push_exp(rr_ids[i], 1'b1, 1'b0);
    bus.req = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      serve(10, 1'b0);
      if (i == 5) bus.req = '0;
      else bus.req[rr_ids[i]] = 1'b1;
    end

    // Reset during WAIT_END with req[1] held.
    bus.golden[1*SIG_W +: SIG_W] = 16'h7777;
    eng_sig = 16'h7777;
    eng_run = 40;
    bus.req = 4'b0010;
    lat = 0;
    while (!bus.bist_start && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("rst_run_start", bus.bist_start, 1);
    repeat (10) @(negedge clk);
    chk("rst_run_busy_before", bus.busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_ack", bus.ack, 0);
    chk("abort_sessions", bus.sessions, 0);
    chk("abort_grant", bus.grant_id, 0);
    exp_sessions = 0;
    push_exp(2'd1, 1'b1, 1'b0);
    serve(44, 1'b1);

    // Watchdog instance: engine never finishes, then a normal session.
    bus2.golden[0*SIG_W +: SIG_W] = 16'hC0DE;
    bus2.golden[1*SIG_W +: SIG_W] = 16'h0BAD;
    bus2.req = 4'b0001;
    lat = 0;
    while (!bus2.bist_start && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("to_start", bus2.bist_start, 1);
    lat = 0;
    while (bus2.ack == '0 && lat < 200) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    chk("to_latency", lat, 22);
    chk("to_ack", bus2.ack, 4'b0001);
    chk("to_err", bus2.timeout_err, 1);
    chk("to_pass", bus2.pass, 0);
    bus2.req = '0;
    @(negedge clk);
    chk("to_flags_clear", {bus2.ack, bus2.timeout_err, bus2.pass}, 0);

    bus2.req = 4'b0010;
    lat = 0;
    while (!bus2.bist_start && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    lat = 0;
    while (bus2.ack == '0 && lat < 200) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      if (lat == 3) begin
        bus2.signature = 16'h0BAD;
        bus2.bist_end  = 1'b1;
      end
    end
    chk("after_to_latency", lat, 5);
    chk("after_to_ack", bus2.ack, 4'b0010);
    chk("after_to_pass", bus2.pass, 1);
    chk("after_to_err", bus2.timeout_err, 0);
    chk("after_to_grant", bus2.grant_id, 1);
    bus2.req = '0;
    @(negedge clk);
    chk("to_sessions", bus2.sessions, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
